// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, serial out, saturating shift counter and word-done pulse.
// Optional recirculating shift enabled by defining UNIV_SHIFT_ROTATE_EN (adds the rotate port).
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
`ifdef UNIV_SHIFT_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CW-1:0]    shift_cnt,
    output logic             done
);

    localparam logic [1:0]    MODE_SHR  = 2'b01;
    localparam logic [1:0]    MODE_SHL  = 2'b10;
    localparam logic [1:0]    MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic             w_in_r;
    logic             w_in_l;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_sout_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_done_nxt;

`ifdef UNIV_SHIFT_ROTATE_EN
    assign w_in_r = rotate ? r_q[0]       : sin;
    assign w_in_l = rotate ? r_q[WIDTH-1] : sin;
`else
    assign w_in_r = sin;
    assign w_in_l = sin;
`endif

    // Counter saturates at WIDTH so done can fire only once per word.
    assign w_cnt_inc = (r_cnt < CNT_FULL) ? r_cnt + 1'b1 : r_cnt;

    always_comb begin
        w_q_nxt    = r_q;
        w_sout_nxt = r_sout;
        w_cnt_nxt  = r_cnt;
        w_done_nxt = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    w_q_nxt    = {w_in_r, r_q[WIDTH-1:1]};
                    w_sout_nxt = r_q[0];
                    w_cnt_nxt  = w_cnt_inc;
                    w_done_nxt = (r_cnt == CNT_LAST);
                end
                MODE_SHL: begin
                    w_q_nxt    = {r_q[WIDTH-2:0], w_in_l};
                    w_sout_nxt = r_q[WIDTH-1];
                    w_cnt_nxt  = w_cnt_inc;
                    w_done_nxt = (r_cnt == CNT_LAST);
                end
                MODE_LOAD: begin
                    w_q_nxt   = d;
                    w_cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_sout <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_sout <= w_sout_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign q         = r_q;
    assign sout      = r_sout;
    assign shift_cnt = r_cnt;
    assign done      = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8); rotate scenario runs when UNIV_SHIFT_ROTATE_EN is defined.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         sin = 1'b0;
    logic [W-1:0] d = '0;
    logic         rotate = 1'b0;
    logic [W-1:0] q;
    logic         sout;
    logic [3:0]   shift_cnt;
    logic         done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // reference state
    int  m_q, m_sout, m_cnt, m_done;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .d(d),
`ifdef UNIV_SHIFT_ROTATE_EN
        .rotate(rotate),
`endif
        .q(q), .sout(sout), .shift_cnt(shift_cnt), .done(done)
    );

    function automatic logic [13:0] dut_vec();
        return {q, sout, shift_cnt, done};
    endfunction

    function automatic logic [13:0] mdl_vec();
        return {m_q[7:0], m_sout[0], m_cnt[3:0], m_done[0]};
    endfunction

    task automatic model_reset();
        m_q = 0; m_sout = 0; m_cnt = 0; m_done = 0;
    endtask

    // Behavioural model: integer arithmetic on the word, clamped counter.
    task automatic model_step();
        int in_bit, prev;
        bit rot;
`ifdef UNIV_SHIFT_ROTATE_EN
        rot = rotate;
`else
        rot = 1'b0;
`endif
        m_done = 0;
        if (!en || mode == 2'd0) return;
        if (mode == 2'd3) begin
            m_q = int'(d); m_cnt = 0;
            return;
        end
        if (mode == 2'd1) begin
            in_bit = rot ? (m_q % 2) : int'(sin);
            m_sout = m_q % 2;
            m_q = (m_q / 2) + in_bit * (1 << (W - 1));
        end else begin
            in_bit = rot ? (m_q / (1 << (W - 1))) : int'(sin);
            m_sout = m_q / (1 << (W - 1));
            m_q = ((m_q * 2) % (1 << W)) + in_bit;
        end
        prev = m_cnt;
        m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
        m_done = (prev == W - 1) ? 1 : 0;
    endtask

    task automatic cycle(input logic e, input logic [1:0] md, input logic s, input logic [W-1:0] dd);
        en = e; mode = md; sin = s; d = dd;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1'b0; mode = 2'b00; rotate = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 2'b11, 1'b0, 8'hA5);
        en = 1'b1; mode = 2'b01; sin = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({q, sout, shift_cnt, done} !== 14'h0) $display("FAIL reset_async: got %h want 0000", dut_vec());
        else pass_cnt++;
        model_reset();
        @(posedge clk);
        #1;
        chk_cnt++;
        if (dut_vec() !== 14'h0) $display("FAIL reset_held: got %h want 0000", dut_vec());
        else pass_cnt++;
        rst_n = 1'b1;
        en = 1'b0; mode = 2'b00;
    endtask

    task automatic test_serialize();
        logic [7:0] exp_sout = 8'b1011_0100;
        cycle(1'b1, 2'b11, 1'b0, 8'hB4);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 2'b01, 1'b0, 8'h00);
            chk_cnt++;
            if (sout !== exp_sout[i] || done !== (i == 7) || dut_vec() !== mdl_vec())
                $display("FAIL serialize_step%0d: got %h want %h (sout want %0b)", i, dut_vec(), mdl_vec(), exp_sout[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (q !== 8'h00 || shift_cnt !== 4'd8) $display("FAIL serialize_final: q=%h cnt=%0d want q=00 cnt=8", q, shift_cnt);
        else pass_cnt++;
    endtask

    task automatic test_deserialize();
        logic [7:0] bits = 8'b1011_0010;
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 2'b10, bits[7-i], 8'h00);
            pulses += int'(done);
            chk_cnt++;
            if (dut_vec() !== mdl_vec()) $display("FAIL deser_step%0d: got %h want %h", i, dut_vec(), mdl_vec());
            else pass_cnt++;
        end
        chk_cnt++;
        if (q !== 8'hB2 || pulses != 1) $display("FAIL deser_word: q=%h pulses=%0d want q=b2 pulses=1", q, pulses);
        else pass_cnt++;
        cycle(1'b1, 2'b10, 1'b0, 8'h00);
        chk_cnt++;
        if (q !== 8'h64 || shift_cnt !== 4'd8 || done !== 1'b0)
            $display("FAIL deser_saturate: q=%h cnt=%0d done=%0b want q=64 cnt=8 done=0", q, shift_cnt, done);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        cycle(1'b1, 2'b11, 1'b0, 8'h3C);
        cycle(1'b1, 2'b01, 1'b1, 8'h00);
        cycle(1'b1, 2'b01, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b01, 1'b1, 8'h00);
            chk_cnt++;
            if (q !== 8'h4F || sout !== 1'b0 || shift_cnt !== 4'd2 || done !== 1'b0)
                $display("FAIL enable_gate%0d: got %h want q=4f sout=0 cnt=2 done=0", i, dut_vec());
            else pass_cnt++;
        end
        cycle(1'b1, 2'b10, 1'b1, 8'h00);
        chk_cnt++;
        if (shift_cnt !== 4'd3 || dut_vec() !== mdl_vec()) $display("FAIL enable_resume: got %h want %h", dut_vec(), mdl_vec());
        else pass_cnt++;
    endtask

    task automatic test_reload();
        int pulses = 0;
        cycle(1'b1, 2'b11, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'b01, 1'b1, 8'h00);
        cycle(1'b1, 2'b11, 1'b0, 8'hFF);
        chk_cnt++;
        if (q !== 8'hFF || shift_cnt !== 4'd0 || done !== 1'b0)
            $display("FAIL reload_load: got %h want q=ff cnt=0 done=0", dut_vec());
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 8'h00);
            pulses += int'(done);
        end
        chk_cnt++;
        if (pulses != 1 || dut_vec() !== mdl_vec()) $display("FAIL reload_word: pulses=%0d got %h want 1 pulse %h", pulses, dut_vec(), mdl_vec());
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
`ifdef UNIV_SHIFT_ROTATE_EN
            rotate = 1'($urandom_range(0, 1));
`endif
            cycle(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3) == 3 && $urandom_range(0, 3) != 0 ? 1 : $urandom_range(0, 3)),
                  1'($urandom), 8'($urandom));
            chk_cnt++;
            if (dut_vec() !== mdl_vec()) $display("FAIL random_cyc%0d: got %h want %h", i, dut_vec(), mdl_vec());
            else pass_cnt++;
        end
        rotate = 1'b0;
    endtask

`ifdef UNIV_SHIFT_ROTATE_EN
    task automatic test_rotate();
        int pulses = 0;
        rotate = 1'b0;
        cycle(1'b1, 2'b11, 1'b0, 8'h81);
        rotate = 1'b1;
        cycle(1'b1, 2'b01, 1'b0, 8'h00);
        chk_cnt++;
        if (q !== 8'hC0 || sout !== 1'b1) $display("FAIL rotate_first: q=%h sout=%0b want q=c0 sout=1", q, sout);
        else pass_cnt++;
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, 2'b01, 1'b0, 8'h00);
            pulses += int'(done);
        end
        chk_cnt++;
        if (q !== 8'h81 || done !== 1'b1 || pulses != 1) $display("FAIL rotate_word: q=%h done=%0b pulses=%0d want q=81 done=1 pulses=1", q, done, pulses);
        else pass_cnt++;
        rotate = 1'b0;
    endtask
`endif

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        #1;
        chk_cnt++;
        if (dut_vec() !== 14'h0) $display("FAIL reset_state: got %h want 0000", dut_vec());
        else pass_cnt++;
        test_reset();
        test_serialize();
        test_deserialize();
        test_enable();
        test_reload();
`ifdef UNIV_SHIFT_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
